// File: rtl/axis_out_pkg.sv
// Shared definitions for the axis_out output stage: FSM encoding and
// the pointer-width helper used by the output buffer.
package axis_out_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest r with 2**r >= n; usable in parameter declarations.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_out_if.sv
// Streaming bundle around axis_out: FIR result input and AXI-Stream sm_* output.
interface axis_out_if #(
    parameter int unsigned pDATA_WIDTH = 32
);

    logic [pDATA_WIDTH-1:0] fir_data;
    logic                   fir_valid;
    logic                   fir_ready;
    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    // master: the axis_out block itself (drives fir_ready and the sm_* master side)
    modport master (
        input  fir_data, fir_valid, sm_tready,
        output fir_ready, sm_tvalid, sm_tdata, sm_tlast
    );

    // slave: FIR core plus stream sink surrounding the block
    modport slave (
        output fir_data, fir_valid, sm_tready,
        input  fir_ready, sm_tvalid, sm_tdata, sm_tlast
    );

endinterface

// File: rtl/axis_out_fifo.sv
// Small synchronous FIFO buffering FIR results ahead of the AXI-Stream port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axis_out_fifo
    import axis_out_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pFIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [pDATA_WIDTH-1:0] push_data,
    input  logic                   pop,
    output logic [pDATA_WIDTH-1:0] head_data,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW      = clog2(pFIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [pDATA_WIDTH-1:0] mem_q [pFIFO_DEPTH];
    logic [AW:0]            wr_ptr_q;
    logic [AW:0]            rd_ptr_q;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; entry validity is defined purely by the
    // pointers, so stale contents can never be observed as valid data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/axis_out.sv
// AXI-Stream master for FIR results: buffers beats, applies backpressure to the
// FIR core, marks the last beat of a frame and pulses axis_done at frame end.
module axis_out
    import axis_out_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pLEN_WIDTH  = 32,
    parameter int unsigned pFIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_out_if.master            bus,
    input  logic                  ap_start_i,
    input  logic [pLEN_WIDTH-1:0] data_length_i,
    output logic                  axis_done_o,
    output logic                  busy_o
);

    localparam logic [pLEN_WIDTH-1:0] CNT_ONE = 1;

    state_e                 state_q;
    logic [pLEN_WIDTH-1:0]  len_q;
    logic [pLEN_WIDTH-1:0]  in_cnt_q;
    logic [pLEN_WIDTH-1:0]  out_cnt_q;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [pDATA_WIDTH-1:0] head_data;

    axis_out_fifo #(
        .pDATA_WIDTH (pDATA_WIDTH),
        .pFIFO_DEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.fir_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Acceptance depends only on registered state, never on sm_tready.
    assign bus.fir_ready = (state_q == RUN) && !fifo_full && (in_cnt_q < len_q);
    assign push          = bus.fir_valid && bus.fir_ready;

    // Data is forced to zero while invalid so reset leaves every output at 0.
    assign bus.sm_tvalid = !fifo_empty;
    assign bus.sm_tdata  = fifo_empty ? '0 : head_data;
    assign bus.sm_tlast  = bus.sm_tvalid && (out_cnt_q == len_q - CNT_ONE);
    assign pop           = bus.sm_tvalid && bus.sm_tready;

    assign axis_done_o   = (state_q == DONE);
    assign busy_o        = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ap_start_i) begin
                        len_q     <= data_length_i;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        state_q   <= (data_length_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) in_cnt_q  <= in_cnt_q + CNT_ONE;
                    if (pop)  out_cnt_q <= out_cnt_q + CNT_ONE;
                    if (pop && bus.sm_tlast) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_out.sv
// Directed bench for axis_out: queue scoreboard on the sm_* stream plus
// handshake, frame-length and done-pulse checks sampled on the falling edge.
module tb_axis_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic [31:0] data_length = '0;
    logic        axis_done;
    logic        busy;

    axis_out_if #(.pDATA_WIDTH(32)) bus ();

    axis_out #(
        .pDATA_WIDTH (32),
        .pLEN_WIDTH  (32),
        .pFIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ap_start_i    (ap_start),
        .data_length_i (data_length),
        .axis_done_o   (axis_done),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          frame_len = 0;
    int          beats = 0;
    int          tlast_cnt = 0;
    int          done_cnt = 0;
    int          accepted = 0;
    int          start_cyc = 0;
    int          last_cyc = 0;
    int          ready_mode = 0;     // 0: always ready, 1: stalled, 2: random
    bit          lat_chk = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] src_q[$];
    int          push_cyc_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.fir_valid = (src_q.size() > 0);
        bus.fir_data  = (src_q.size() > 0) ? src_q[0] : '0;
        case (ready_mode)
            0:       bus.sm_tready = 1'b1;
            1:       bus.sm_tready = 1'b0;
            default: bus.sm_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock: sample and score at the falling edge, drive after the rising edge.
    task automatic tick();
        logic [31:0] exp_d;
        logic [31:0] src_d;
        int          pc;
        @(negedge clk);
        if (prev_stall) begin
            check("hold_tvalid", bus.sm_tvalid, 1'b1);
            check("hold_tdata", bus.sm_tdata, prev_data);
            check("hold_tlast", bus.sm_tlast, prev_last);
        end
        if (bus.fir_ready) check("ready_within_len", accepted < frame_len, 1'b1);
        if (bus.fir_valid && bus.fir_ready) begin
            check("busy_on_push", busy, 1'b1);
            src_d = src_q.pop_front();
            push_cyc_q.push_back(cycle);
            accepted++;
        end
        if (bus.sm_tvalid && bus.sm_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", bus.sm_tdata, 64'hx);
            end else begin
                exp_d = exp_q.pop_front();
                check("tdata", bus.sm_tdata, exp_d);
                check("tlast", bus.sm_tlast, beats == frame_len - 1);
            end
            if (push_cyc_q.size() > 0) begin
                pc = push_cyc_q.pop_front();
                if (lat_chk) check("latency", cycle, pc + 1);
            end
            if (bus.sm_tlast) begin
                tlast_cnt++;
                last_cyc = cycle;
            end
            beats++;
        end
        if (axis_done) begin
            done_cnt++;
            check("done_timing", cycle, last_cyc + 1);
            check("busy_at_done", busy, 1'b0);
        end
        prev_stall = bus.sm_tvalid && !bus.sm_tready;
        prev_data  = bus.sm_tdata;
        prev_last  = bus.sm_tlast;
        cycle++;
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic start_frame(input int len);
        frame_len   = len;
        beats       = 0;
        tlast_cnt   = 0;
        done_cnt    = 0;
        accepted    = 0;
        start_cyc   = cycle;
        last_cyc    = cycle;
        ap_start    = 1'b1;
        data_length = len;
        tick();
        ap_start    = 1'b0;
        data_length = '0;
    endtask

    task automatic end_frame(input int len);
        for (int n = 0; n < 1000 && done_cnt == 0; n++) tick();
        check("done_seen", done_cnt, 1);
        tick();
        check("beat_count", beats, len);
        check("tlast_count", tlast_cnt, (len > 0) ? 1 : 0);
        check("scoreboard_empty", exp_q.size(), 0);
        check("idle_busy", busy, 1'b0);
        check("idle_done", axis_done, 1'b0);
    endtask

    task automatic load(input logic [31:0] v);
        src_q.push_back(v);
        exp_q.push_back(v);
    endtask

    initial begin
        logic [31:0] v;
        bus.fir_valid = 1'b0;
        bus.fir_data  = '0;
        bus.sm_tready = 1'b0;
        #1;
        check("rst_tvalid", bus.sm_tvalid, 1'b0);
        check("rst_tdata", bus.sm_tdata, 32'h0);
        check("rst_fir_ready", bus.fir_ready, 1'b0);
        check("rst_done", axis_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();

        // 1: len=4, always ready, back-to-back beats, one-cycle latency
        ready_mode = 0;
        lat_chk    = 1'b1;
        for (int i = 1; i <= 4; i++) load(i);
        drive_inputs();
        start_frame(4);
        end_frame(4);
        lat_chk = 1'b0;

        // 2: len=8, sink stalled for 10 cycles -> only 4 accepted, head held
        ready_mode = 1;
        for (int i = 1; i <= 8; i++) load(i);
        drive_inputs();
        start_frame(8);
        repeat (10) tick();
        check("stall_accepted", accepted, 4);
        check("stall_fir_ready", bus.fir_ready, 1'b0);
        check("stall_tvalid", bus.sm_tvalid, 1'b1);
        check("stall_tdata", bus.sm_tdata, 32'd1);
        ready_mode = 0;
        end_frame(8);

        // 3: len=64 random data, random sink readiness
        ready_mode = 2;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            load(v);
        end
        drive_inputs();
        start_frame(64);
        end_frame(64);

        // 4: zero-length frame
        ready_mode = 0;
        start_frame(0);
        end_frame(0);
        check("zero_accepted", accepted, 0);

        // 5: len=2, three beats offered, second ap_start mid-frame ignored
        src_q.push_back(32'h10);
        src_q.push_back(32'h20);
        src_q.push_back(32'h30);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h20);
        drive_inputs();
        start_frame(2);
        ap_start    = 1'b1;
        data_length = 5;
        tick();
        ap_start    = 1'b0;
        data_length = '0;
        end_frame(2);
        check("len2_accepted", accepted, 2);
        check("len2_leftover", src_q.size(), 1);
        src_q.delete();
        drive_inputs();
        repeat (4) tick();
        check("len2_single_done", done_cnt, 1);

        // 6: reset mid-frame, then a clean two-beat frame
        for (int i = 1; i <= 8; i++) load(32'h100 + i);
        drive_inputs();
        start_frame(8);
        for (int n = 0; n < 100 && beats < 3; n++) tick();
        check("pre_reset_beats", beats, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", bus.sm_tvalid, 1'b0);
        check("arst_tdata", bus.sm_tdata, 32'h0);
        check("arst_tlast", bus.sm_tlast, 1'b0);
        check("arst_fir_ready", bus.fir_ready, 1'b0);
        check("arst_done", axis_done, 1'b0);
        check("arst_busy", busy, 1'b0);
        src_q.delete();
        exp_q.delete();
        push_cyc_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
        load(32'hA5A5_0001);
        load(32'h5A5A_0002);
        drive_inputs();
        start_frame(2);
        end_frame(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
